// File: rtl/multiplier_datapath_if.sv
// multiplier_datapath_if: command and register-view bundle between the multiplier FSM and its datapath
interface multiplier_datapath_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] S;
  logic clr_ld;
  logic clearA;
  logic addsub;
  logic Sub_en;
  logic Shift_en;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic Xval;
  logic bout;
  modport master (
    output S, clr_ld, clearA, addsub, Sub_en, Shift_en,
    input  Aval, Bval, Xval, bout
  );
  modport slave (
    input  S, clr_ld, clearA, addsub, Sub_en, Shift_en,
    output Aval, Bval, Xval, bout
  );
endinterface

// File: rtl/multiplier_datapath.sv
// multiplier_datapath: {X, A, B} registers with a WIDTH+1 bit add/sub and arithmetic right shift
module multiplier_datapath #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  multiplier_datapath_if.slave bus
);
  logic x;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] s_ext;
  logic [WIDTH:0] sum;
  assign a_ext = {a[WIDTH-1], a};
  assign s_ext = {bus.S[WIDTH-1], bus.S};
  // Subtraction as A + ~S + 1; the carry out of bit WIDTH is discarded
  assign sum = bus.Sub_en ? a_ext + ~s_ext + 1'b1 : a_ext + s_ext;
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= 1'b0;
      a <= '0;
      b <= '0;
    end else if (bus.clr_ld) begin
      x <= 1'b0;
      a <= '0;
      b <= bus.S;
    end else if (bus.clearA) begin
      x <= 1'b0;
      a <= '0;
    end else if (bus.addsub) begin
      {x, a} <= sum;
    end else if (bus.Shift_en) begin
      a <= {x, a[WIDTH-1:1]};
      b <= {a[0], b[WIDTH-1:1]};
    end
  end
  assign bus.Aval = a;
  assign bus.Bval = b;
  assign bus.Xval = x;
  assign bus.bout = b[0];
endmodule
